// File: rtl/axi_pkt_framer_if.sv
// AXI-Stream style handshake bundle shared by the framer input and output sides.
// No storage: plain wires, zero latency.
// Backpressure travels on tready from the slave modport back to the master.
interface axi_pkt_framer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    // Producer side: drives valid/data/last, observes ready.
    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    // Consumer side of an unframed stream: tlast is not carried upstream.
    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/axi_pkt_framer.sv
// Cuts an unframed sample stream into frames of frame_len payload words, last word flagged with tlast.
// Latency: one clk from s_axis transfer to m_axis_tvalid through a single output register stage.
// Backpressure: s_axis.tready = (output register empty or being drained); held output stays stable while stalled.
// Build option PKT_FRAMER_HDR_EN: when defined each frame is preceded by a header word
// {zeros, frame_cnt[15:0], len[15:0]}; when undefined the output is payload only.
module axi_pkt_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 async_reset_n,
    input  logic [LEN_WIDTH-1:0] frame_len,
    axi_pkt_framer_if.slave      s_axis,
    axi_pkt_framer_if.master     m_axis,
    output logic [15:0]          frame_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef PKT_FRAMER_HDR_EN
        HEADER  = 2'd1,
`endif
        PAYLOAD = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [15:0]           frame_cnt_q;

    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_dat;
    logic                  out_last;

    logic                  ld;
    logic                  s_rdy;
    logic                  len_ld;
    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  seq_inc;
    logic                  nxt_vld;
    logic [DATA_WIDTH-1:0] nxt_dat;
    logic                  nxt_last;
`ifdef PKT_FRAMER_HDR_EN
    logic [DATA_WIDTH-1:0] hdr_dat;
`endif

    // The output register may take a new word when it is empty or its word leaves this cycle.
    assign ld = ~out_vld | m_axis.tready;

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_dat;
    assign m_axis.tlast  = out_last;
    assign frame_cnt     = frame_cnt_q;

    // Next-state and datapath control; tready is a function of state and ld only, never of s_axis.tvalid.
    always_comb begin
        state_nxt = state_q;
        s_rdy     = 1'b0;
        len_ld    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        seq_inc   = 1'b0;
        nxt_vld   = 1'b0;
        nxt_dat   = s_axis.tdata;
        nxt_last  = 1'b0;
`ifdef PKT_FRAMER_HDR_EN
        hdr_dat        = '0;
        hdr_dat[31:0]  = {frame_cnt_q, 16'(len_q)};
`endif
        case (state_q)
            IDLE: begin
                // A zero length never starts a frame; the length is frozen here for the whole frame.
                if (s_axis.tvalid && (frame_len != '0)) begin
                    len_ld = 1'b1;
`ifdef PKT_FRAMER_HDR_EN
                    state_nxt = HEADER;
`else
                    cnt_clr   = 1'b1;
                    state_nxt = PAYLOAD;
`endif
                end
            end
`ifdef PKT_FRAMER_HDR_EN
            HEADER: begin
                if (ld) begin
                    nxt_vld   = 1'b1;
                    nxt_dat   = hdr_dat;
                    cnt_clr   = 1'b1;
                    state_nxt = PAYLOAD;
                end
            end
`endif
            PAYLOAD: begin
                s_rdy = ld;
                if (s_axis.tvalid && ld) begin
                    nxt_vld = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt_q == (len_q - LEN_WIDTH'(1))) begin
                        nxt_last  = 1'b1;
                        seq_inc   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame control state: FSM, latched length, payload counter and sequence number.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (len_ld) begin
                len_q <= frame_len;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
            if (seq_inc) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // Output stage: loads only when ld, so a stalled word keeps valid/data/last unchanged.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
        end else if (ld) begin
            out_vld  <= nxt_vld;
            out_last <= nxt_vld & nxt_last;
            if (nxt_vld) begin
                out_dat <= nxt_dat;
            end
        end
    end

endmodule

// File: tb/tb_axi_pkt_framer.sv
// Self-checking bench for axi_pkt_framer: randomized upstream valid / downstream ready
// against a frame-level reference model (queues of expected words), with stall-hold checks.
// Works with PKT_FRAMER_HDR_EN defined or undefined.
module tb_axi_pkt_framer;

    localparam int DW = 32;
    localparam int LW = 16;
`ifdef PKT_FRAMER_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          async_reset_n;
    logic [LW-1:0] frame_len;
    logic [15:0]   frame_cnt;

    axi_pkt_framer_if #(.DATA_WIDTH(DW)) s_if ();
    axi_pkt_framer_if #(.DATA_WIDTH(DW)) m_if ();

    axi_pkt_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .frame_len     (frame_len),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] src_q[$];
    logic [DW:0]   exp_q[$];
    logic [DW:0]   obs_q[$];
    int            xfer_cyc[$];
    int            vld_pct  = 100;
    int            rdy_mode = 0;
    int            rdy_ph   = 0;
    int            cyc      = 0;
    logic [15:0]   exp_seq  = 16'd0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic          prev_last;

    // Stimulus driver: new inputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (src_q.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = src_q[0];
        end else begin
            s_if.tvalid = 1'b0;
            s_if.tdata  = $urandom;
        end
        case (rdy_mode)
            0: m_if.tready = 1'b1;
            1: begin
                m_if.tready = (rdy_ph == 0);
                rdy_ph = (rdy_ph + 1) % 3;
            end
            default: m_if.tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor on the falling edge: records handshakes and checks that stalled output holds.
    always @(negedge clk) begin
        if (!async_reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_dat || m_if.tlast !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold @cyc %0d: got vld=%0b data=%08h last=%0b, expected vld=1 data=%08h last=%0b",
                             cyc, m_if.tvalid, m_if.tdata, m_if.tlast, prev_dat, prev_last);
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_dat   = m_if.tdata;
            prev_last  = m_if.tlast;
            if (s_if.tvalid && s_if.tready && src_q.size() > 0) begin
                void'(src_q.pop_front());
                xfer_cyc.push_back(cyc);
            end
            if (m_if.tvalid && m_if.tready) begin
                obs_q.push_back({m_if.tlast, m_if.tdata});
            end
        end
    end

    // Reference model: queues upstream words and the framed stream they must produce.
    task automatic gen_frames(input int nfr, input int len, input bit cnt_data, input logic [DW-1:0] base);
        logic [DW-1:0] d;
        for (int f = 0; f < nfr; f++) begin
            if (HDR) exp_q.push_back({1'b0, exp_seq, 16'(len)});
            for (int w = 0; w < len; w++) begin
                d = cnt_data ? base + DW'(f * len + w) : DW'($urandom);
                src_q.push_back(d);
                exp_q.push_back({(w == len - 1), d});
            end
            exp_seq = exp_seq + 16'd1;
        end
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && obs_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (6) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 async_reset_n = 1'b0;
        src_q.delete(); obs_q.delete(); exp_q.delete(); xfer_cyc.delete();
        exp_seq = 16'd0;
        repeat (2) @(posedge clk);
        #1 async_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0b, expected 0", m_if.tvalid); end
        n_checks++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %0b, expected 0", m_if.tlast); end
        n_checks++; if (m_if.tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %08h, expected 0", m_if.tdata); end
        n_checks++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %0b, expected 0", s_if.tready); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %04h, expected 0000", frame_cnt); end
        @(posedge clk);
        #1 async_reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int need;
        need = HDR ? 3 : 2;
        frame_len = 16'd4; vld_pct = 100; rdy_mode = 0; exp_seq = 16'd0;
        gen_frames(1, 4, 1'b1, 32'h100);
        for (int c = 0; c < 60 && obs_q.size() < need; c++) @(posedge clk);
        n_checks++;
        if (obs_q.size() < need) begin n_fail++; $display("FAIL midrst_reach: got %0d words, expected %0d", obs_q.size(), need); end
        #3 async_reset_n = 1'b0;
        #1;
        n_checks++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %0b, expected 0", m_if.tvalid); end
        n_checks++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL midrst_tlast: got %0b, expected 0", m_if.tlast); end
        n_checks++; if (m_if.tdata !== '0) begin n_fail++; $display("FAIL midrst_tdata: got %08h, expected 0", m_if.tdata); end
        n_checks++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready: got %0b, expected 0", s_if.tready); end
        src_q.delete(); obs_q.delete(); exp_q.delete();
        exp_seq = 16'd0;
        @(posedge clk);
        #1 async_reset_n = 1'b1;
        gen_frames(1, 4, 1'b1, 32'hA0);
        drain(80);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midrst_len: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midrst_word%0d: got last=%0b data=%08h, expected last=%0b data=%08h",
                         i, obs_q[i][DW], obs_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_basic();
        pulse_reset();
        frame_len = 16'd4; vld_pct = 100; rdy_mode = 0;
        gen_frames(2, 4, 1'b1, 32'd1);
        drain(100);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_len: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_word%0d: got last=%0b data=%08h, expected last=%0b data=%08h",
                         i, obs_q[i][DW], obs_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL basic_frame_cnt: got %04h, expected 0002", frame_cnt); end
    endtask

    task automatic test_backpressure();
        frame_len = 16'd3; vld_pct = 100; rdy_mode = 1; rdy_ph = 0;
        gen_frames(3, 3, 1'b0, '0);
        drain(300);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_len: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_word%0d: got last=%0b data=%08h, expected last=%0b data=%08h",
                         i, obs_q[i][DW], obs_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_len_edge();
        rdy_mode = 0; vld_pct = 100;
        frame_len = 16'd0;
        gen_frames(1, 1, 1'b1, 32'h55);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL len0_tready c%0d: got %0b, expected 0", c, s_if.tready); end
            n_checks++;
            if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL len0_tvalid c%0d: got %0b, expected 0", c, m_if.tvalid); end
        end
        @(posedge clk);
        #1 frame_len = 16'd1;
        drain(60);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL len1_len: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL len1_word%0d: got last=%0b data=%08h, expected last=%0b data=%08h",
                         i, obs_q[i][DW], obs_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int gap;
        frame_len = 16'd4; vld_pct = 100; rdy_mode = 0;
        xfer_cyc.delete();
        gen_frames(3, 4, 1'b1, 32'h200);
        drain(120);
        n_checks++;
        if (xfer_cyc.size() !== 12) begin n_fail++; $display("FAIL b2b_xfers: got %0d, expected 12", xfer_cyc.size()); end
        for (int i = 1; i < xfer_cyc.size() && i < 12; i++) begin
            gap = (i % 4 == 0) ? (HDR ? 3 : 2) : 1;
            n_checks++;
            if (xfer_cyc[i] - xfer_cyc[i-1] !== gap) begin
                n_fail++;
                $display("FAIL b2b_gap%0d: got %0d cycles, expected %0d", i, xfer_cyc[i] - xfer_cyc[i-1], gap);
            end
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got last=%0b data=%08h, expected last=%0b data=%08h",
                         i, obs_q[i][DW], obs_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            frame_len = 16'($urandom_range(1, 6));
            vld_pct   = $urandom_range(30, 100);
            rdy_mode  = 2;
            gen_frames(4, int'(frame_len), 1'b0, '0);
            drain(800);
            n_checks++;
            if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d words, expected %0d", r, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d: got last=%0b data=%08h, expected last=%0b data=%08h",
                             r, i, obs_q[i][DW], obs_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
                end
            end
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_wrap();
        vld_pct = 100; rdy_mode = 0;
        @(posedge clk);
        force dut.frame_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.frame_cnt_q;
        @(negedge clk);
        n_checks++;
        if (frame_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preset: got %04h, expected fffe", frame_cnt); end
        exp_seq = 16'hFFFE;
        frame_len = 16'd2;
        gen_frames(3, 2, 1'b1, 32'h300);
        drain(100);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wrap_len: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got last=%0b data=%08h, expected last=%0b data=%08h",
                         i, obs_q[i][DW], obs_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if (frame_cnt !== 16'h0001) begin n_fail++; $display("FAIL wrap_frame_cnt: got %04h, expected 0001", frame_cnt); end
    endtask

    initial begin
        async_reset_n = 1'b0;
        frame_len     = '0;
        s_if.tvalid   = 1'b0;
        s_if.tdata    = '0;
        m_if.tready   = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_basic();
        test_backpressure();
        test_len_edge();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no completion, expected completion");
        $fatal(1, "time limit");
    end

endmodule
